vga_pixel_arbiter: RTL and testbench

- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) among several drawing engines: maze scanner, erase-box and draw-box.
- Replaces ad-hoc combinational priority muxing with a registered req/gnt/done arbiter, so exactly one engine owns the port at any time.
- Sits between the drawing engines and vga_adapter, alongside the game handshake FSM.

---
 rtl/vga_arb_pkg.sv | 39 +++
 rtl/arb_pick.sv | 45 ++++
 rtl/vga_pixel_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_pixel_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : vga_arb_pkg                                              |
// | Purpose   : Shared types, constants and width helpers for the VGA    |
// |             pixel-port arbiter and its picker.                       |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package vga_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Requester indices on the pixel port.
  localparam int REQ_MAZE  = 0;
  localparam int REQ_ERASE = 1;
  localparam int REQ_DRAW  = 2;

  // Default widths.
  localparam int DEF_N_REQ = 3;
  localparam int DEF_X_W   = 9;
  localparam int DEF_Y_W   = 9;
  localparam int DEF_C_W   = 3;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the grant-length counter (at least one bit).
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : arb_pick                                                 |
// | Purpose   : Combinational winner picker. Fixed priority (lowest      |
// |             index wins) or rotating priority starting after the      |
// |             last owner.                                              |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module arb_pick #(
  parameter int N_REQ       = 3,
  parameter int ROUND_ROBIN = 0,
  parameter int IDX_W       = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  int   w_idx;
  logic w_unused_last;

  // In fixed-priority builds the last owner plays no part in the search.
  assign w_unused_last = ^i_last_owner;

  // Scan the requesters from the search start and take the first one set.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ROUND_ROBIN != 0) begin
        w_idx = (int'(i_last_owner) + 1 + k) % N_REQ;
      end else begin
        w_idx = k;
      end
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : vga_pixel_arbiter                                        |
// | Purpose   : Registered req/gnt/done arbiter that gives exactly one   |
// |             drawing engine ownership of the VGA adapter pixel port.  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module vga_pixel_arbiter
  import vga_arb_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int X_W            = DEF_X_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int C_W            = DEF_C_W,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [N_REQ*X_W-1:0] x_in,
  input  logic [N_REQ*Y_W-1:0] y_in,
  input  logic [N_REQ*C_W-1:0] colour_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]  r_owner, w_owner_nxt;
  logic [IDX_W-1:0]  r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_plot, w_plot_nxt;
  logic              r_err, w_err_nxt;
  logic [X_W-1:0]    r_x, w_x_nxt;
  logic [Y_W-1:0]    r_y, w_y_nxt;
  logic [C_W-1:0]    r_c, w_c_nxt;

  logic [IDX_W-1:0]  w_winner;
  logic              w_pick_valid;
  logic [N_REQ-1:0]  w_onehot;
  logic [X_W-1:0]    w_sel_x;
  logic [Y_W-1:0]    w_sel_y;
  logic [C_W-1:0]    w_sel_c;
  logic              w_own_req;
  logic              w_own_done;
  logic              w_tmo;

  arb_pick #(
    .N_REQ       (N_REQ),
    .ROUND_ROBIN (ROUND_ROBIN),
    .IDX_W       (IDX_W)
  ) u_pick (
    .i_req        (req),
    .i_last_owner (r_last),
    .o_winner     (w_winner),
    .o_valid      (w_pick_valid)
  );

  assign w_onehot = N_REQ'(1) << w_winner;

  // Owner's coordinate slice and handshake bits; other requesters are ignored.
  always_comb begin
    w_sel_x    = x_in[int'(r_owner)*X_W +: X_W];
    w_sel_y    = y_in[int'(r_owner)*Y_W +: Y_W];
    w_sel_c    = colour_in[int'(r_owner)*C_W +: C_W];
    w_own_req  = req[r_owner];
    w_own_done = done[r_owner];
    w_tmo      = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);
  end

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_plot_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_c_nxt     = r_c;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_onehot;
          w_owner_nxt = w_winner;
          w_cnt_nxt   = '0;
        end
      end
      GRANT: begin
        w_x_nxt = w_sel_x;
        w_y_nxt = w_sel_y;
        w_c_nxt = w_sel_c;
        if (w_own_done || !w_own_req || w_tmo) begin
          // A done coinciding with expiry counts as a clean completion.
          w_state_nxt = RELEASE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_owner;
          if (w_tmo && !w_own_done) begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_plot_nxt = w_own_req & ~w_own_done;
          w_cnt_nxt  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 1'b1);
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset forces the port free immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_plot  <= 1'b0;
      r_err   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_plot  <= w_plot_nxt;
      r_err   <= w_err_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_c     <= w_c_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign vga_x       = r_x;
  assign vga_y       = r_y;
  assign vga_colour  = r_c;
  assign vga_plot    = r_plot;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_vga_pixel_arbiter                                     |
// | Purpose   : Self-checking bench: cycle vector table on a fixed-      |
// |             priority arbiter with timeout, plus timeout, async reset |
// |             and round-robin ordering sequences.                      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_vga_pixel_arbiter;

  logic clk = 1'b0;
  logic resetn;

  logic [2:0]  req_a, done_a, req_b, done_b;
  logic [26:0] x_in;
  logic [26:0] y_in;
  logic [8:0]  c_in;

  logic [2:0] gnt_a, gnt_b;
  logic [8:0] vx_a, vy_a, vx_b, vy_b;
  logic [2:0] vc_a, vc_b;
  logic       plot_a, plot_b, busy_a, busy_b, err_a, err_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Fixed priority, 8-cycle timeout.
  vga_pixel_arbiter #(.N_REQ(3), .X_W(9), .Y_W(9), .C_W(3),
                      .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .resetn(resetn), .req(req_a), .done(done_a),
    .x_in(x_in), .y_in(y_in), .colour_in(c_in),
    .gnt(gnt_a), .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a),
    .vga_plot(plot_a), .busy(busy_a), .timeout_err(err_a));

  // Rotating priority, no timeout.
  vga_pixel_arbiter #(.N_REQ(3), .X_W(9), .Y_W(9), .C_W(3),
                      .ROUND_ROBIN(1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .done(done_b),
    .x_in(x_in), .y_in(y_in), .colour_in(c_in),
    .gnt(gnt_b), .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b),
    .vga_plot(plot_b), .busy(busy_b), .timeout_err(err_b));

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic       plot;
    logic       busy;
    logic       err;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;

    // req  done  gnt  plot busy err  x       y     c
    vecs[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd0,   9'd0, 3'd0};
    vecs[1]  = '{3'b110, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 9'd0,   9'd0, 3'd0};
    vecs[2]  = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[3]  = '{3'b110, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[4]  = '{3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[5]  = '{3'b100, 3'b000, 3'b100, 1'b0, 1'b1, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[6]  = '{3'b100, 3'b000, 3'b100, 1'b1, 1'b1, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[8]  = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[9]  = '{3'b111, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[10] = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0, 9'd10,  9'd5, 3'd1};
    vecs[11] = '{3'b111, 3'b010, 3'b001, 1'b1, 1'b1, 1'b0, 9'd10,  9'd5, 3'd1};
    vecs[12] = '{3'b111, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 9'd10,  9'd5, 3'd1};
    vecs[13] = '{3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd10,  9'd5, 3'd1};
    vecs[14] = '{3'b110, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 9'd10,  9'd5, 3'd1};
    vecs[15] = '{3'b110, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[16] = '{3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[17] = '{3'b100, 3'b000, 3'b100, 1'b0, 1'b1, 1'b0, 9'd40,  9'd6, 3'd2};
    vecs[18] = '{3'b100, 3'b000, 3'b100, 1'b1, 1'b1, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[19] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 9'd200, 9'd7, 3'd3};
    vecs[20] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 9'd200, 9'd7, 3'd3};

    x_in   = {9'd200, 9'd40, 9'd10};
    y_in   = {9'd7,   9'd6,  9'd5};
    c_in   = {3'd3,   3'd2,  3'd1};
    req_a  = '0; done_a = '0; req_b = '0; done_b = '0;
    resetn = 1'b0;

    // Outputs held at zero while reset is asserted.
    #12;
    chk("reset_a", {gnt_a, plot_a, busy_a, err_a, vx_a, vy_a, vc_a}, 32'd0);
    chk("reset_b", {gnt_b, plot_b, busy_b, err_b}, 32'd0);
    tick();
    resetn = 1'b1;

    // Cycle vector table on the fixed-priority instance.
    for (int i = 0; i < 21; i++) begin
      req_a  = vecs[i].req;
      done_a = vecs[i].done;
      tick();
      if ({gnt_a, plot_a, busy_a, err_a, vx_a, vy_a, vc_a} !==
          {vecs[i].gnt, vecs[i].plot, vecs[i].busy, vecs[i].err,
           vecs[i].x, vecs[i].y, vecs[i].c}) begin
        $display("FAIL vec%0d: got gnt=%b plot=%b busy=%b err=%b x=%0d y=%0d c=%0d expected gnt=%b plot=%b busy=%b err=%b x=%0d y=%0d c=%0d",
                 i, gnt_a, plot_a, busy_a, err_a, vx_a, vy_a, vc_a,
                 vecs[i].gnt, vecs[i].plot, vecs[i].busy, vecs[i].err,
                 vecs[i].x, vecs[i].y, vecs[i].c);
        n_err++;
      end
      n_checks++;
    end
    done_a = '0;

    // Timeout: owner never signals done, grant lasts exactly 8 cycles.
    req_a = 3'b001;
    req_b = 3'b010;
    tick();
    chk("tmo_grant", gnt_a, 32'h1);
    begin
      int n_hi;
      n_hi = 1;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (gnt_a == 3'b000) break;
        n_hi++;
      end
      chk("tmo_len", n_hi, 32'd8);
    end
    chk("tmo_err_set", err_a, 32'h1);
    tick();
    tick();
    chk("tmo_regrant", gnt_a, 32'h1);
    chk("tmo_err_sticky", err_a, 32'h1);
    tick();
    chk("pre_rst_plot", {plot_a, plot_b}, 32'h3);

    // Asynchronous reset in the middle of a clock period.
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_a", {gnt_a, plot_a, busy_a, err_a}, 32'd0);
    chk("async_rst_b", {gnt_b, plot_b, busy_b}, 32'd0);
    req_a = '0;
    req_b = 3'b111;
    tick();
    resetn = 1'b1;
    tick();
    chk("rr_restart_idx0", gnt_b, 32'h1);

    // done on the same edge the timeout would expire: no error.
    req_a = 3'b001;
    tick();
    chk("dt_grant", gnt_a, 32'h1);
    for (int k = 0; k < 7; k++) tick();
    chk("dt_still_held", gnt_a, 32'h1);
    done_a = 3'b001;
    tick();
    done_a = '0;
    req_a  = '0;
    chk("dt_release_noerr", {gnt_a, plot_a, err_a}, 32'd0);

    // Rotating priority with all three requesting: order 0,1,2,0,1,2.
    resetn = 1'b0;
    req_b  = '0;
    done_b = '0;
    tick();
    resetn = 1'b1;
    req_b  = 3'b111;
    for (int g = 0; g < 6; g++) begin
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (gnt_b != 3'b000) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        n_checks++;
        n_err++;
        $display("FAIL rr_wait%0d: got no grant within 10 cycles expected grant to %0d", g, g % 3);
      end else begin
        chk($sformatf("rr_order%0d", g), gnt_b, 32'(1 << (g % 3)));
        for (int k = 0; k < 3; k++) tick();
        done_b = gnt_b;
        tick();
        done_b = '0;
      end
    end
    req_b = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
